// File: rtl/fix_msg_pkg.sv
// fix_msg_pkg: shared message-type codes, request-queue FSM states and request width for the
// outbound message request path between session_manager and create_message.
package fix_msg_pkg;
    localparam int VALUE_DATA_WIDTH = 32;
    localparam int VALUE_SIZE       = 6;
    localparam logic [3:0] MSG_LOGON      = 4'h1;
    localparam logic [3:0] MSG_LOGOUT     = 4'h2;
    localparam logic [3:0] MSG_HEARTBEAT  = 4'h3;
    localparam logic [3:0] MSG_RESEND_REQ = 4'h4;
    typedef enum logic {ST_IDLE, ST_WAIT_DONE} cm_state_e;
    // Packed request layout, MSB first: {type[3:0], compId, s_v, err[3:0]}
    function automatic int req_width(int vw, int sz);
        return 8 + vw + sz;
    endfunction
endpackage

// File: rtl/msg_req_fifo.sv
// msg_req_fifo: 2**DEPTH_LOG2-entry synchronous FIFO with show-ahead head, tail peek and occupancy.
// Caller guarantees push only when not full (or popping) and pop only when not empty.
module msg_req_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          head,
    output logic [W-1:0]          tail,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    logic [W-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wp, rp;
    logic [DEPTH_LOG2-1:0] tail_idx;

    // Extra pointer MSB separates full from empty when the low bits coincide
    assign count    = wp - rp;
    assign empty    = wp == rp;
    assign full     = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) && (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
    assign tail_idx = wp[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
    assign head     = mem[rp[DEPTH_LOG2-1:0]];
    assign tail     = mem[tail_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + (DEPTH_LOG2+1)'(1);
            if (pop) rp <= rp + (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[DEPTH_LOG2-1:0]] <= wdata;
    end
endmodule

// File: rtl/create_msg_request_queue.sv
// create_msg_request_queue: queues session_manager message requests and issues them one at a time
// to create_message via start/busy/done. Optional `HEARTBEAT_COALESCE_EN drops duplicate tail heartbeats.
module create_msg_request_queue
    import fix_msg_pkg::*;
#(
    parameter int VALUE_WIDTH  = VALUE_DATA_WIDTH,
    parameter int SIZE         = VALUE_SIZE,
    parameter int DEPTH_LOG2   = 3,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   initiate_msg_i,
    input  logic [3:0]             create_message_i,
    input  logic [VALUE_WIDTH-1:0] targetCompId_i,
    input  logic [SIZE-1:0]        s_v_targetCompId_i,
    input  logic [3:0]             error_type_i,
    input  logic                   cm_busy_i,
    input  logic                   cm_done_i,
    output logic                   initiate_msg_o,
    output logic [3:0]             create_message_o,
    output logic [VALUE_WIDTH-1:0] targetCompId_o,
    output logic [SIZE-1:0]        s_v_targetCompId_o,
    output logic [3:0]             error_type_o,
    output logic                   queue_full_o,
    output logic                   overflow_o,
    output logic                   timeout_err_o,
    output logic [DEPTH_LOG2:0]    pending_o
);
    localparam int RW = req_width(VALUE_WIDTH, SIZE);
    localparam int TW = $clog2(DONE_TIMEOUT) + 1;

    logic [RW-1:0] wdata, head, tail;
    logic push, pop, empty, hb_drop, expire, unused_tail;
    cm_state_e state, state_nx;
    logic [TW-1:0] timer;

    assign wdata       = {create_message_i, targetCompId_i, s_v_targetCompId_i, error_type_i};
    assign unused_tail = ^tail;
`ifdef HEARTBEAT_COALESCE_EN
    // The tail only counts as "still queued" if this cycle's pop is not taking it
    assign hb_drop = create_message_i == MSG_HEARTBEAT && !empty
                  && !(pop && pending_o == (DEPTH_LOG2+1)'(1))
                  && tail[RW-1 -: 4] == MSG_HEARTBEAT && tail[RW-5 -: VALUE_WIDTH] == targetCompId_i;
`else
    assign hb_drop = 1'b0;
`endif
    assign push = initiate_msg_i && !hb_drop && (!queue_full_o || pop);

    msg_req_fifo #(.W(RW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .tail  (tail),
        .full  (queue_full_o),
        .empty (empty),
        .count (pending_o)
    );

    always_comb begin
        pop      = state == ST_IDLE && !empty && !cm_busy_i;
        expire   = state == ST_WAIT_DONE && !cm_done_i && timer == TW'(DONE_TIMEOUT - 1);
        state_nx = pop ? ST_WAIT_DONE : (cm_done_i || expire) ? ST_IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            timer              <= '0;
            initiate_msg_o     <= 1'b0;
            create_message_o   <= '0;
            targetCompId_o     <= '0;
            s_v_targetCompId_o <= '0;
            error_type_o       <= '0;
            overflow_o         <= 1'b0;
            timeout_err_o      <= 1'b0;
        end else begin
            state          <= state_nx;
            timer          <= (state == ST_WAIT_DONE && state_nx == ST_WAIT_DONE) ? timer + TW'(1) : '0;
            initiate_msg_o <= pop;
            timeout_err_o  <= expire;
            overflow_o     <= overflow_o | (initiate_msg_i && !hb_drop && !push);
            if (pop) {create_message_o, targetCompId_o, s_v_targetCompId_o, error_type_o} <= head;
        end
    end
endmodule
